// File: rtl/small_calculator_driver_pkg.sv
// rtl/small_calculator_driver_pkg.sv - shared types and widths for the calculator go/done driver
package small_calculator_driver_pkg;

  localparam int CALC_DATA_W = 4;
  localparam int CALC_OP_W   = 2;
  localparam int CALC_CS_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } drv_state_e;

endpackage

// File: rtl/small_calculator_timeout.sv
// rtl/small_calculator_timeout.sv - loadable down-counter with terminal-count flag for go/done initiators
module small_calculator_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  // Loading TIMEOUT-1 makes tc fire on the TIMEOUT-th enabled cycle after load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/small_calculator_driver.sv
// rtl/small_calculator_driver.sv - initiator for the small_calculator go/done protocol
module small_calculator_driver
  import small_calculator_driver_pkg::*;
#(
  parameter int DATA_W  = CALC_DATA_W,
  parameter int OP_W    = CALC_OP_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [DATA_W-1:0]    req_a,
  input  logic [DATA_W-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_timeout,
  output logic [CALC_CS_W-1:0] rsp_cs,
  output logic                 calc_go,
  output logic [OP_W-1:0]      calc_op,
  output logic [DATA_W-1:0]    calc_in1,
  output logic [DATA_W-1:0]    calc_in2,
  input  logic [DATA_W-1:0]    calc_out,
  input  logic [CALC_CS_W-1:0] calc_cs,
  input  logic                 calc_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     txn_count
);

  drv_state_e state;
  logic       accept;
  logic       timer_tc;
  logic       timer_en;

  assign req_ready = (state == ST_IDLE) && !rsp_valid;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != ST_IDLE);
  assign timer_en  = (state == ST_RUN);

  small_calculator_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      calc_go     <= 1'b0;
      calc_op     <= '0;
      calc_in1    <= '0;
      calc_in2    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      rsp_cs      <= '0;
      txn_count   <= '0;
    end else begin
      // A new response can only be produced after acceptance, which requires
      // rsp_valid low, so consume and produce never meet on one edge.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            calc_op  <= req_op;
            calc_in1 <= req_a;
            calc_in2 <= req_b;
            calc_go  <= 1'b1;
            state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (calc_done) begin
            rsp_data    <= calc_out;
            rsp_timeout <= 1'b0;
            rsp_cs      <= '0;
            rsp_valid   <= 1'b1;
            txn_count   <= txn_count + 1'b1;
            calc_go     <= 1'b0;
            state       <= ST_DRAIN;
          end else if (timer_tc) begin
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            rsp_cs      <= calc_cs;
            rsp_valid   <= 1'b1;
            calc_go     <= 1'b0;
            state       <= ST_DRAIN;
          end
        end

        // Wait for done to return low so a level-held done is seen only once.
        ST_DRAIN: begin
          calc_go <= 1'b0;
          if (!calc_done) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          calc_go <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
